imu_frame_packer: RTL and testbench

Sequential front end for the attitude filter path. Accepts raw signed 16-bit IMU samples one word per handshake in fixed channel order, converts each to FP16 (IEEE 754 half), scales gyro channels to rad/s, and presents one complete six-channel frame on a valid/ready output. It is the producer feeding the clocked wrapper around the combinational Madgwick filter, which consumes FP16 accel (any units) and gyro (rad/s).

---
 rtl/imu_frame_packer_pkg.sv | 26 ++
 rtl/fp_mul.sv | 76 +++++++
 rtl/imu_frame_packer_int16_to_fp16.sv | 54 +++++
 rtl/imu_frame_packer.sv | 129 ++++++++++++
 tb/tb_imu_frame_packer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imu_frame_packer_pkg.sv
// imu_frame_packer_pkg
//   Shared definitions for the IMU frame packer: FP16 constants, the
//   exponent bias and the fixed channel order of a six-word IMU frame.
package imu_frame_packer_pkg;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [4:0]  FP16_BIAS = 5'd15;
    localparam int unsigned NUM_CH    = 6;

    // Channel order on the input stream; the value doubles as the
    // "next expected channel" index.
    typedef enum logic [2:0] {
        CH_AX = 3'd0,
        CH_AY = 3'd1,
        CH_AZ = 3'd2,
        CH_GX = 3'd3,
        CH_GY = 3'd4,
        CH_GZ = 3'd5
    } ch_idx_t;

    function automatic logic is_gyro(input ch_idx_t ch);
        return (ch >= CH_GX);
    endfunction

endpackage

// File: rtl/fp_mul.sv
// fp_mul
//   Combinational FP16 multiplier, round-to-nearest-even.
//   Subnormal operands/results are flushed to signed zero, overflow
//   saturates to infinity, NaN or inf*0 yields a quiet NaN.
//   Ports: a, b  - FP16 operands
//          y     - FP16 product
module fp_mul
    import imu_frame_packer_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    logic              sign;
    logic [4:0]        ea, eb;
    logic [9:0]        ma, mb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [21:0]       prod;
    logic signed [7:0] exp_s;
    logic [9:0]        mant;
    logic              guard, sticky;
    logic [10:0]       mant_r;

    always_comb begin
        sign   = a[15] ^ b[15];
        ea     = a[14:10];
        eb     = b[14:10];
        ma     = a[9:0];
        mb     = b[9:0];
        a_zero = (ea == 5'd0);
        b_zero = (eb == 5'd0);
        a_inf  = (ea == 5'd31) && (ma == 10'd0);
        b_inf  = (eb == 5'd31) && (mb == 10'd0);
        a_nan  = (ea == 5'd31) && (ma != 10'd0);
        b_nan  = (eb == 5'd31) && (mb != 10'd0);

        prod  = {11'd0, 1'b1, ma} * {11'd0, 1'b1, mb};
        exp_s = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd15;

        // Product of two 1.x significands lies in [1,4): normalise by one bit.
        if (prod[21]) begin
            mant   = prod[20:11];
            guard  = prod[10];
            sticky = |prod[9:0];
            exp_s  = exp_s + 8'sd1;
        end else begin
            mant   = prod[19:10];
            guard  = prod[9];
            sticky = |prod[8:0];
        end

        mant_r = {1'b0, mant} + {10'd0, guard && (sticky || mant[0])};
        if (mant_r[10]) begin
            mant  = '0;
            exp_s = exp_s + 8'sd1;
        end else begin
            mant  = mant_r[9:0];
        end

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            y = FP16_QNAN;
        end else if (a_inf || b_inf) begin
            y = {sign, 5'd31, 10'd0};
        end else if (a_zero || b_zero) begin
            y = {sign, 15'd0};
        end else if (exp_s >= 8'sd31) begin
            y = {sign, 5'd31, 10'd0};
        end else if (exp_s <= 8'sd0) begin
            y = {sign, 15'd0};
        end else begin
            y = {sign, exp_s[4:0], mant};
        end
    end

endmodule

// File: rtl/imu_frame_packer_int16_to_fp16.sv
// int16_to_fp16
//   Combinational conversion of a signed 16-bit integer to FP16 with
//   round-to-nearest-even. The full int16 range is representable, so the
//   result never overflows (extremes are 0x7800 / 0xF800).
//   Ports: din  - two's-complement integer
//          dout - FP16 value
module int16_to_fp16
    import imu_frame_packer_pkg::*;
(
    input  logic [15:0] din,
    output logic [15:0] dout
);

    logic        sign;
    logic [15:0] mag;
    logic [3:0]  pos;
    logic [14:0] norm;
    logic [9:0]  mant;
    logic        guard, sticky;
    logic [10:0] mant_r;
    logic [4:0]  expo;

    always_comb begin
        sign = din[15];
        // -32768 negates to 0x8000, which is the correct unsigned magnitude.
        mag  = sign ? (~din + 16'd1) : din;

        pos = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (mag[i]) begin
                pos = i[3:0];
            end
        end

        // Shift the leading one out of the top; what remains is mantissa
        // followed by the dropped bits used for rounding.
        norm   = mag[14:0] << (4'd15 - pos);
        mant   = norm[14:5];
        guard  = norm[4];
        sticky = |norm[3:0];
        expo   = {1'b0, pos} + FP16_BIAS;

        mant_r = {1'b0, mant} + {10'd0, guard && (sticky || mant[0])};
        if (mant_r[10]) begin
            mant = '0;
            expo = expo + 5'd1;
        end else begin
            mant = mant_r[9:0];
        end

        dout = (din == 16'd0) ? FP16_ZERO : {sign, expo, mant};
    end

endmodule

// File: rtl/imu_frame_packer.sv
// imu_frame_packer
//   Collects six raw IMU words (accel x/y/z, gyro x/y/z) from a
//   valid/ready stream, converts each to FP16 as it is accepted, scales
//   gyro words to rad/s and presents a complete frame on valid/ready.
//   Ports:
//     clk, reset            - clock, synchronous active-high reset
//     in_valid/in_ready     - input handshake
//     in_data, in_first     - raw sample, channel-0 marker
//     gyro_scale            - FP16 rad/s per LSB, sampled per gyro word
//     out_valid/out_ready   - output frame handshake
//     accel_*, gyro_*       - FP16 frame outputs
//     err_sync              - one-cycle pulse on a framing error
//     frame_count           - delivered frames, wrapping
module imu_frame_packer
    import imu_frame_packer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_first,
    input  logic [15:0] gyro_scale,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic [15:0] gyro_x,
    output logic [15:0] gyro_y,
    output logic [15:0] gyro_z,
    output logic        err_sync,
    output logic [15:0] frame_count
);

    ch_idx_t     idx_q;
    logic [15:0] stage_q [NUM_CH-1];
    logic [15:0] ax_q, ay_q, az_q, gx_q, gy_q, gz_q;
    logic        out_valid_q;
    logic        err_q;
    logic [15:0] frame_count_q;

    logic [15:0] conv;
    logic [15:0] scaled;
    logic [15:0] ch_val;
    logic        accept;

    int16_to_fp16 u_conv (
        .din  (in_data),
        .dout (conv)
    );

    fp_mul u_gyro_mul (
        .a (conv),
        .b (gyro_scale),
        .y (scaled)
    );

    // The last channel may be taken while the consumer drains the held
    // frame, so a full-rate stream never stalls when out_ready stays high.
    assign in_ready = !reset &&
                      ((idx_q != CH_GZ) || !out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign ch_val   = is_gyro(idx_q) ? scaled : conv;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q         <= CH_AX;
            out_valid_q   <= 1'b0;
            err_q         <= 1'b0;
            frame_count_q <= '0;
            ax_q          <= FP16_ZERO;
            ay_q          <= FP16_ZERO;
            az_q          <= FP16_ZERO;
            gx_q          <= FP16_ZERO;
            gy_q          <= FP16_ZERO;
            gz_q          <= FP16_ZERO;
            for (int unsigned i = 0; i < NUM_CH - 1; i++) begin
                stage_q[i] <= FP16_ZERO;
            end
        end else begin
            err_q <= 1'b0;

            if (out_valid_q && out_ready) begin
                out_valid_q   <= 1'b0;
                frame_count_q <= frame_count_q + 16'd1;
            end

            if (accept) begin
                if (in_first) begin
                    // Channel-0 marker always restarts the frame; mid-frame
                    // it also signals that the previous partial was lost.
                    stage_q[CH_AX] <= conv;
                    idx_q          <= CH_AY;
                    if (idx_q != CH_AX) begin
                        err_q <= 1'b1;
                    end
                end else if (idx_q == CH_AX) begin
                    err_q <= 1'b1;
                end else if (idx_q == CH_GZ) begin
                    ax_q        <= stage_q[CH_AX];
                    ay_q        <= stage_q[CH_AY];
                    az_q        <= stage_q[CH_AZ];
                    gx_q        <= stage_q[CH_GX];
                    gy_q        <= stage_q[CH_GY];
                    gz_q        <= scaled;
                    // Overrides the clear above when a frame is taken and
                    // replaced in the same cycle.
                    out_valid_q <= 1'b1;
                    idx_q       <= CH_AX;
                end else begin
                    stage_q[idx_q] <= ch_val;
                    idx_q          <= ch_idx_t'(idx_q + 3'd1);
                end
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign accel_x     = ax_q;
    assign accel_y     = ay_q;
    assign accel_z     = az_q;
    assign gyro_x      = gx_q;
    assign gyro_y      = gy_q;
    assign gyro_z      = gz_q;
    assign err_sync    = err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_imu_frame_packer.sv
module tb_imu_frame_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_first;
    logic [15:0] gyro_scale;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] accel_x, accel_y, accel_z;
    logic [15:0] gyro_x, gyro_y, gyro_z;
    logic        err_sync;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    imu_frame_packer dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_first    (in_first),
        .gyro_scale  (gyro_scale),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .accel_x     (accel_x),
        .accel_y     (accel_y),
        .accel_z     (accel_z),
        .gyro_x      (gyro_x),
        .gyro_y      (gyro_y),
        .gyro_z      (gyro_z),
        .err_sync    (err_sync),
        .frame_count (frame_count)
    );

    typedef struct {
        logic [15:0] w [6];
        logic [15:0] scale;
        logic [15:0] e [6];
    } vec_t;

    vec_t        vecs [4];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_count;

    function automatic vec_t mk(
        input logic [15:0] w0, w1, w2, w3, w4, w5, sc,
        input logic [15:0] e0, e1, e2, e3, e4, e5);
        vec_t v;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
        v.w[3] = w3; v.w[4] = w4; v.w[5] = w5;
        v.scale = sc;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2;
        v.e[3] = e3; v.e[4] = e4; v.e[5] = e5;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h, want 0x%04h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", name, act, exp);
    endtask

    task automatic send_word(input logic [15:0] d, input logic first);
        int n = 0;
        in_data  = d;
        in_first = first;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check1("in_ready_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic send_frame(input vec_t v);
        gyro_scale = v.scale;
        for (int i = 0; i < 6; i++) send_word(v.w[i], i == 0);
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, ".accel_x"}, accel_x, v.e[0]);
        check({tag, ".accel_y"}, accel_y, v.e[1]);
        check({tag, ".accel_z"}, accel_z, v.e[2]);
        check({tag, ".gyro_x"},  gyro_x,  v.e[3]);
        check({tag, ".gyro_y"},  gyro_y,  v.e[4]);
        check({tag, ".gyro_z"},  gyro_z,  v.e[5]);
    endtask

    task automatic take_frame(input string tag, input logic [15:0] cnt);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check1({tag, ".out_valid_cleared"}, out_valid, 1'b0);
        check({tag, ".frame_count"}, frame_count, cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(16'h0000, 16'h0001, 16'hFFFF, 16'h07FF, 16'h0FFF, 16'h8000, 16'h3C00,
                     16'h0000, 16'h3C00, 16'hBC00, 16'h67FF, 16'h6C00, 16'hF800);
        vecs[1] = mk(16'h7FFF, 16'h8001, 16'h0400, 16'h0004, 16'h0004, 16'h0004, 16'h3800,
                     16'h7800, 16'hF800, 16'h6400, 16'h4000, 16'h4000, 16'h4000);
        vecs[2] = mk(16'hFFFE, 16'h0003, 16'h0801, 16'hFFFD, 16'hFFFD, 16'h0006, 16'h4000,
                     16'hC000, 16'h4200, 16'h6800, 16'hC600, 16'hC600, 16'h4A00);
        vecs[3] = mk(16'h0803, 16'h1001, 16'hEFFD, 16'h0064, 16'h03E8, 16'hFFFF, 16'h3C00,
                     16'h6802, 16'h6C00, 16'hEC01, 16'h5640, 16'h63D0, 16'hBC00);

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_first   = 1'b0;
        out_ready  = 1'b0;
        gyro_scale = 16'h3C00;
        repeat (3) @(posedge clk);
        #1;
        check1("rst.in_ready",  in_ready,  1'b0);
        check1("rst.out_valid", out_valid, 1'b0);
        check("rst.accel_x",    accel_x,   16'h0000);
        check("rst.gyro_z",     gyro_z,    16'h0000);
        check1("rst.err_sync",  err_sync,  1'b0);
        check("rst.frame_count", frame_count, 16'h0000);
        reset = 1'b0;
        #1;
        check1("post_rst.in_ready", in_ready, 1'b1);

        // Backpressure: frame A held while frame B collects up to channel 5.
        send_frame(vecs[0]);
        check1("bp.latency_out_valid", out_valid, 1'b1);
        check_outputs("bp.frameA", vecs[0]);
        gyro_scale = vecs[1].scale;
        for (int i = 0; i < 5; i++) send_word(vecs[1].w[i], i == 0);
        in_valid = 1'b1;
        in_data  = vecs[1].w[5];
        in_first = 1'b0;
        #1;
        check1("bp.in_ready_low", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check1("bp.in_ready_still_low", in_ready, 1'b0);
        check("bp.hold_accel_y", accel_y, 16'h3C00);
        check("bp.hold_gyro_z",  gyro_z,  16'hF800);
        check("bp.hold_count",   frame_count, 16'h0000);
        out_ready = 1'b1;
        #1;
        check1("bp.in_ready_release", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check1("bp.out_valid_stays", out_valid, 1'b1);
        check_outputs("bp.frameB", vecs[1]);
        check("bp.count_0_to_1", frame_count, 16'h0001);
        take_frame("bp.take", 16'h0002);
        exp_count = 16'h0002;

        // Table of conversion / scaling frames.
        for (int i = 0; i < 4; i++) begin
            send_frame(vecs[i]);
            check1($sformatf("vec%0d.out_valid", i), out_valid, 1'b1);
            check_outputs($sformatf("vec%0d", i), vecs[i]);
            exp_count = exp_count + 16'd1;
            take_frame($sformatf("vec%0d", i), exp_count);
        end

        // Resync: in_first on the third word restarts the frame from it.
        gyro_scale = 16'h3800;
        send_word(16'h0001, 1'b1);
        send_word(16'h0002, 1'b0);
        check1("resync.no_err", err_sync, 1'b0);
        send_word(16'h0064, 1'b1);
        check1("resync.err_pulse", err_sync, 1'b1);
        @(posedge clk); #1;
        check1("resync.err_once", err_sync, 1'b0);
        send_word(16'h03E8, 1'b0);
        send_word(16'hFFFF, 1'b0);
        send_word(16'h0004, 1'b0);
        send_word(16'h0004, 1'b0);
        check1("resync.not_yet_valid", out_valid, 1'b0);
        send_word(16'h0004, 1'b0);
        check1("resync.out_valid", out_valid, 1'b1);
        check("resync.accel_x", accel_x, 16'h5640);
        check("resync.accel_y", accel_y, 16'h63D0);
        check("resync.accel_z", accel_z, 16'hBC00);
        check("resync.gyro_x",  gyro_x,  16'h4000);
        exp_count = exp_count + 16'd1;
        take_frame("resync", exp_count);

        // Word without in_first at idx 0 is dropped.
        send_word(16'h0007, 1'b0);
        check1("drop.err_pulse", err_sync, 1'b1);
        send_word(16'h07FF, 1'b1);
        check1("drop.err_clear", err_sync, 1'b0);
        send_word(16'h0001, 1'b0);
        send_word(16'hFFFF, 1'b0);
        send_word(16'h0004, 1'b0);
        send_word(16'h0004, 1'b0);
        send_word(16'h0004, 1'b0);
        check("drop.accel_x", accel_x, 16'h67FF);
        check("drop.accel_y", accel_y, 16'h3C00);
        check("drop.gyro_z",  gyro_z,  16'h4000);
        exp_count = exp_count + 16'd1;
        take_frame("drop", exp_count);

        // Reset with a held frame and a 3-word partial.
        send_frame(vecs[2]);
        gyro_scale = vecs[3].scale;
        for (int i = 0; i < 3; i++) send_word(vecs[3].w[i], i == 0);
        reset = 1'b1;
        #1;
        check1("midrst.in_ready_low", in_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        check1("midrst.out_valid", out_valid, 1'b0);
        check("midrst.accel_x",    accel_x,   16'h0000);
        check("midrst.gyro_z",     gyro_z,    16'h0000);
        check("midrst.frame_count", frame_count, 16'h0000);
        send_frame(vecs[3]);
        check1("midrst.new_valid", out_valid, 1'b1);
        check_outputs("midrst", vecs[3]);
        take_frame("midrst", 16'h0001);

        // Wrap of the delivery counter.
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        @(posedge clk); #1;
        send_frame(vecs[1]);
        check_outputs("wrap", vecs[1]);
        take_frame("wrap", 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
